wb_dma_arbiter: RTL

- Shares the processor-module Wishbone bus between the VM2 CPU master and N DMA masters (disk and network controllers).
- Drives the CPU bus-grant input; CPU grant low makes the core stall and wait for ack.
- Grants DMA masters in round-robin order, never preempts a bus cycle in progress, and caps DMA burst length.
- Guarantees the CPU a minimum bus window between DMA tenures.

---
 rtl/wb_dma_arbiter_if.sv | 55 +++++
 rtl/wb_dma_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_dma_arbiter_if.sv
// Bus bundle for the CPU/DMA Wishbone arbiter: CPU port, N packed DMA ports,
// the shared master port and the grant/owner status.
interface wb_dma_arbiter_if #(
    parameter int N = 2
);
    logic              cpu_cyc_i;
    logic              cpu_stb_i;
    logic              cpu_we_i;
    logic [1:0]        cpu_sel_i;
    logic [15:0]       cpu_adr_i;
    logic [15:0]       cpu_dat_i;
    logic              cpu_ack_o;
    logic              cpu_gnt_o;

    logic [N-1:0]      dma_req_i;
    logic [N-1:0]      dma_gnt_o;
    logic [N-1:0]      dma_cyc_i;
    logic [N-1:0]      dma_stb_i;
    logic [N-1:0]      dma_we_i;
    logic [2*N-1:0]    dma_sel_i;
    logic [16*N-1:0]   dma_adr_i;
    logic [16*N-1:0]   dma_dat_i;
    logic [N-1:0]      dma_ack_o;

    logic              m_cyc_o;
    logic              m_stb_o;
    logic              m_we_o;
    logic [1:0]        m_sel_o;
    logic [15:0]       m_adr_o;
    logic [15:0]       m_dat_o;
    logic              m_ack_i;
    logic [2:0]        owner_o;

    // Arbiter side.
    modport slave (
        input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        output cpu_ack_o, cpu_gnt_o,
        input  dma_req_i, dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
        output dma_gnt_o, dma_ack_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  m_ack_i,
        output owner_o
    );

    // Requesters and shared-bus slave side.
    modport master (
        output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        input  cpu_ack_o, cpu_gnt_o,
        output dma_req_i, dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
        input  dma_gnt_o, dma_ack_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output m_ack_i,
        input  owner_o
    );
endinterface

// File: rtl/wb_dma_arbiter.sv
// Shares the processor Wishbone bus between the CPU and N DMA masters with
// round-robin DMA selection, a per-tenure transfer cap and a guaranteed CPU window.
module wb_dma_arbiter #(
    parameter int N        = 2,
    parameter int MAX_XFER = 16,
    parameter int CPU_SLOT = 8
) (
    input  logic                 clk_p,
    input  logic                 rst_n,
    wb_dma_arbiter_if.slave      bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
    localparam int XW = (MAX_XFER > 0) ? $clog2(MAX_XFER + 1) : 1;

    typedef enum logic {
        S_CPU,
        S_DMA
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [PW-1:0]   r_dmaIdx;
    logic [PW-1:0]   w_nextDmaIdx;
    logic [PW-1:0]   r_rrPtr;
    logic [PW-1:0]   w_nextRrPtr;
    logic [PW-1:0]   w_selIdx;
    logic [SW-1:0]   r_slotCnt;
    logic [SW-1:0]   w_nextSlotCnt;
    logic [XW-1:0]   r_xferCnt;
    logic [XW-1:0]   w_nextXferCnt;
    logic            w_anyReq;
    logic            w_capHit;
    logic            w_release;
    logic [N-1:0]    w_dmaGnt;
    logic            w_cpuGnt;

    assign w_anyReq  = |bus.dma_req_i;
    assign w_capHit  = (MAX_XFER != 0) && (r_xferCnt >= XW'(MAX_XFER));
    assign w_release = !bus.dma_cyc_i[r_dmaIdx] && (!bus.dma_req_i[r_dmaIdx] || w_capHit);

    // Scan downward so the requester closest to r_rrPtr is the last to win.
    always_comb begin
        w_selIdx = r_rrPtr;
        for (int i = N - 1; i >= 0; i--) begin
            int            j;
            logic [PW-1:0] idx;
            j = int'(r_rrPtr) + i;
            if (j >= N) j = j - N;
            idx = PW'(j);
            if (bus.dma_req_i[idx]) w_selIdx = idx;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CPU;
            r_dmaIdx  <= '0;
            r_rrPtr   <= '0;
            r_slotCnt <= '0;
            r_xferCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_dmaIdx  <= w_nextDmaIdx;
            r_rrPtr   <= w_nextRrPtr;
            r_slotCnt <= w_nextSlotCnt;
            r_xferCnt <= w_nextXferCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextDmaIdx  = r_dmaIdx;
        w_nextRrPtr   = r_rrPtr;
        w_nextSlotCnt = r_slotCnt;
        w_nextXferCnt = r_xferCnt;
        case (r_state)
            S_CPU: begin
                if (r_slotCnt != '0) w_nextSlotCnt = r_slotCnt - 1'b1;
                // A CPU cycle in progress is never broken.
                if (w_anyReq && !bus.cpu_cyc_i && (r_slotCnt == '0)) begin
                    w_nextState   = S_DMA;
                    w_nextDmaIdx  = w_selIdx;
                    w_nextXferCnt = '0;
                end
            end
            S_DMA: begin
                if (bus.m_ack_i && (r_xferCnt != '1)) w_nextXferCnt = r_xferCnt + 1'b1;
                if (w_release) begin
                    w_nextState   = S_CPU;
                    w_nextSlotCnt = SW'(CPU_SLOT);
                    w_nextRrPtr   = (r_dmaIdx == PW'(N - 1)) ? '0 : r_dmaIdx + 1'b1;
                end
            end
            default: w_nextState = S_CPU;
        endcase
    end

    always_comb begin
        w_dmaGnt = '0;
        if (r_state == S_DMA) w_dmaGnt[r_dmaIdx] = 1'b1;
    end

    assign w_cpuGnt      = (r_state == S_CPU);
    assign bus.cpu_gnt_o = w_cpuGnt;
    assign bus.dma_gnt_o = w_dmaGnt;
    assign bus.owner_o   = w_cpuGnt ? 3'd0 : 3'(r_dmaIdx) + 3'd1;

    // Acks are suppressed while reset is held so an in-flight ack goes nowhere.
    assign bus.cpu_ack_o = bus.m_ack_i & rst_n & w_cpuGnt;
    assign bus.dma_ack_o = w_dmaGnt & {N{bus.m_ack_i & rst_n}};

    always_comb begin
        bus.m_cyc_o = bus.cpu_cyc_i;
        bus.m_stb_o = bus.cpu_stb_i;
        bus.m_we_o  = bus.cpu_we_i;
        bus.m_sel_o = bus.cpu_sel_i;
        bus.m_adr_o = bus.cpu_adr_i;
        bus.m_dat_o = bus.cpu_dat_i;
        if (r_state == S_DMA) begin
            for (int k = 0; k < N; k++) begin
                if (r_dmaIdx == PW'(k)) begin
                    bus.m_cyc_o = bus.dma_cyc_i[k];
                    bus.m_stb_o = bus.dma_stb_i[k];
                    bus.m_we_o  = bus.dma_we_i[k];
                    bus.m_sel_o = bus.dma_sel_i[2*k +: 2];
                    bus.m_adr_o = bus.dma_adr_i[16*k +: 16];
                    bus.m_dat_o = bus.dma_dat_i[16*k +: 16];
                end
            end
        end
    end
endmodule
